// File: rtl/seg_io_pkg.sv
// rtl/seg_io_pkg.sv - register offsets, CTRL/STATUS bit positions and hex-to-segment table for seg_io_ctrl
package seg_io_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_UP_IE  = 2;
    localparam int CTRL_DN_IE  = 3;
    localparam int CTRL_DP_LSB = 8;

    localparam int STAT_UP_EVT = 0;
    localparam int STAT_DN_EVT = 1;
    localparam int STAT_UP_LVL = 2;
    localparam int STAT_DN_LVL = 3;

    // Active-low segments, bit order g..a
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_io_debounce.sv
// rtl/seg_io_debounce.sv - 2-flop synchroniser plus stable-count debouncer for one push-button
module seg_io_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the count
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/seg_io_ctrl.sv
// rtl/seg_io_ctrl.sv - memory-mapped 7-segment scanner with debounced up/down buttons
// Optional irq output and CTRL interrupt enables when SEG_IO_IRQ_EN is defined.
module seg_io_ctrl
    import seg_io_pkg::*;
#(
    parameter int               WIDTH           = 32,
    parameter int               DIGITS          = 4,
    parameter logic [WIDTH-1:0] BASE            = 32'h0000_0080,
    parameter int               SCAN_DIV        = 50000,
    parameter int               DEBOUNCE_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    input  logic              memwrite,
    input  logic [WIDTH-1:0]  adr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    output logic [DIGITS-1:0] AN,
    output logic [7:0]        CX
`ifdef SEG_IO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_data;
    logic                r_enable;
    logic [DIGITS-1:0]   r_dp;
    logic [1:0]          r_evt;
    logic [1:0]          r_lvl_d;
    logic [SC_W-1:0]     r_scan_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [7:0]          r_cx;

    logic                w_hit;
    logic                w_wr;
    logic [1:0]          w_sel;
    logic [1:0]          w_lvl;
    logic [1:0]          w_rise;
    logic [1:0]          w_clr;
    logic [1:0]          w_ie;
    logic [3:0]          w_nib;
    logic                w_unused;

    assign w_hit    = (adr[WIDTH-1:4] == BASE[WIDTH-1:4]);
    assign w_sel    = adr[3:2];
    assign w_wr     = memwrite & w_hit;
    assign w_clr    = (w_wr && w_sel == OFF_STATUS) ? writedata[STAT_DN_EVT:STAT_UP_EVT] : 2'b00;
    assign w_rise   = w_lvl & ~r_lvl_d;
    assign w_nib    = r_data[{r_idx, 2'b00} +: 4];
    assign w_unused = ^{adr[1:0], writedata};

    seg_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .reset(reset), .i_raw(up), .o_level(w_lvl[0])
    );

    seg_io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(clk), .reset(reset), .i_raw(down), .o_level(w_lvl[1])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_enable <= 1'b0;
            r_dp     <= '0;
            r_evt    <= 2'b00;
            r_lvl_d  <= 2'b00;
        end else begin
            r_lvl_d <= w_lvl;
            // A rising level beats a coincident write-1-to-clear
            r_evt   <= w_rise | (r_evt & ~w_clr);
            if (w_wr && w_sel == OFF_DATA) begin
                r_data <= writedata[4*DIGITS-1:0];
            end
            if (w_wr && w_sel == OFF_CTRL) begin
                r_enable <= writedata[CTRL_ENABLE];
                r_dp     <= writedata[CTRL_DP_LSB +: DIGITS];
            end
        end
    end

`ifdef SEG_IO_IRQ_EN
    logic [1:0] r_ie;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie <= 2'b00;
        end else if (w_wr && w_sel == OFF_CTRL) begin
            r_ie <= {writedata[CTRL_DN_IE], writedata[CTRL_UP_IE]};
        end
    end

    assign w_ie = r_ie;
    assign irq  = |(r_evt & r_ie);
`else
    assign w_ie = 2'b00;
`endif

    // Scanning keeps running while disabled so re-enabling resumes in phase
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= '1;
            r_cx       <= 8'hFF;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (r_enable) begin
                r_an <= ~(DIGITS'(1) << r_idx);
                r_cx <= {~r_dp[r_idx], HEX_SEG[w_nib]};
            end else begin
                r_an <= '1;
                r_cx <= 8'hFF;
            end
        end
    end

    assign AN = r_an;
    assign CX = r_cx;

    always_comb begin
        memdata = '0;
        if (w_hit) begin
            case (w_sel)
                OFF_DATA: memdata[4*DIGITS-1:0] = r_data;
                OFF_CTRL: begin
                    memdata[CTRL_ENABLE]            = r_enable;
                    memdata[CTRL_UP_IE]             = w_ie[0];
                    memdata[CTRL_DN_IE]             = w_ie[1];
                    memdata[CTRL_DP_LSB +: DIGITS]  = r_dp;
                end
                OFF_STATUS: begin
                    memdata[STAT_UP_EVT] = r_evt[0];
                    memdata[STAT_DN_EVT] = r_evt[1];
                    memdata[STAT_UP_LVL] = w_lvl[0];
                    memdata[STAT_DN_LVL] = w_lvl[1];
                end
                OFF_RSVD: memdata = '0;
                default:  memdata = '0;
            endcase
        end
    end

endmodule
